// File: rtl/fft_8p_in_buffer.sv
// fft_8p_in_buffer: serial complex samples -> ping-pong N-sample frames for the FFT core.
// Build with FFT_IN_BITREV_EN defined to store sample k at address bitrev(k).
module fft_8p_in_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic signed [DATA_WIDTH-1:0] s_real,
    input  logic signed [DATA_WIDTH-1:0] s_imag,
    input  logic                         s_last,
    output logic                         frame_valid,
    input  logic                         frame_ready,
    output logic signed [DATA_WIDTH-1:0] x_real [N-1:0],
    output logic signed [DATA_WIDTH-1:0] x_imag [N-1:0],
    output logic                         frame_err
);
    localparam int AW = $clog2(N);

    typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_st_e;

    bank_st_e                     st_q [2];
    bank_st_e                     st_d [2];
    logic                         wr_sel_q, wr_sel_d;
    logic                         rd_sel_q, rd_sel_d;
    logic [AW-1:0]                wr_cnt_q, wr_cnt_d;
    logic                         err_q, err_d;
    logic [N-1:0]                 mask_q [2];
    logic [N-1:0]                 mask_d;
    logic [N-1:0]                 onehot;
    logic signed [DATA_WIDTH-1:0] re_q [2][N];
    logic signed [DATA_WIDTH-1:0] im_q [2][N];
    logic signed [DATA_WIDTH-1:0] hold_re_q [N];
    logic signed [DATA_WIDTH-1:0] hold_im_q [N];
    logic                         accept, close, rel, last_idx;
    logic [AW-1:0]                wr_addr;

`ifdef FFT_IN_BITREV_EN
    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int b = 0; b < AW; b++) r[b] = a[AW-1-b];
        return r;
    endfunction

    assign wr_addr = bitrev(wr_cnt_q);
`else
    assign wr_addr = wr_cnt_q;
`endif

    assign accept   = s_valid && s_ready;
    assign last_idx = (wr_cnt_q == AW'(N - 1));
    assign close    = accept && (last_idx || s_last);
    assign rel      = frame_valid && frame_ready;

    // Bank state register
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q[0]  <= EMPTY;
            st_q[1]  <= EMPTY;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            wr_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            st_q[0]  <= st_d[0];
            st_q[1]  <= st_d[1];
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            wr_cnt_q <= wr_cnt_d;
            err_q    <= err_d;
        end
    end

    // Release and close always target different banks, so both may apply on one edge
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            st_d[b] = st_q[b];
            if (rel && (rd_sel_q == 1'(b))) st_d[b] = EMPTY;
            if (accept && (wr_sel_q == 1'(b))) st_d[b] = close ? FULL : FILLING;
        end
        wr_sel_d = close ? ~wr_sel_q : wr_sel_q;
        rd_sel_d = rel ? ~rd_sel_q : rd_sel_q;
        wr_cnt_d = close ? '0 : (accept ? wr_cnt_q + 1'b1 : wr_cnt_q);
        err_d    = err_q | (accept && (s_last != last_idx));
    end

    always_comb begin
        s_ready     = (st_q[wr_sel_q] != FULL);
        frame_valid = (st_q[rd_sel_q] == FULL);
        frame_err   = err_q;
    end

    // First sample of a frame restarts the written-address mask used for zero-padding
    always_comb begin
        onehot          = '0;
        onehot[wr_addr] = 1'b1;
        mask_d          = ((wr_cnt_q == '0) ? '0 : mask_q[wr_sel_q]) | onehot;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                mask_q[b] <= '0;
                for (int k = 0; k < N; k++) begin
                    re_q[b][k] <= '0;
                    im_q[b][k] <= '0;
                end
            end
        end else if (accept) begin
            re_q[wr_sel_q][wr_addr] <= s_real;
            im_q[wr_sel_q][wr_addr] <= s_imag;
            mask_q[wr_sel_q]        <= mask_d;
        end
    end

    // Outputs follow the read bank while it is full, otherwise replay the last frame shown
    always_comb begin
        for (int k = 0; k < N; k++) begin
            if (frame_valid) begin
                x_real[k] = mask_q[rd_sel_q][k] ? re_q[rd_sel_q][k] : '0;
                x_imag[k] = mask_q[rd_sel_q][k] ? im_q[rd_sel_q][k] : '0;
            end else begin
                x_real[k] = hold_re_q[k];
                x_imag[k] = hold_im_q[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (rst) begin
                hold_re_q[k] <= '0;
                hold_im_q[k] <= '0;
            end else begin
                hold_re_q[k] <= x_real[k];
                hold_im_q[k] <= x_imag[k];
            end
        end
    end

endmodule

// File: tb/tb_fft_8p_in_buffer.sv
// Bench for fft_8p_in_buffer: directed test-plan scenarios plus a random stream,
// all checked against a frame-queue model of the ping-pong buffer.
module tb_fft_8p_in_buffer;
    localparam int DW = 16;
    localparam int N  = 8;
    localparam int LG = 3;

    typedef logic [N-1:0][DW-1:0] frame_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 s_valid, s_ready, s_last;
    logic signed [DW-1:0] s_real, s_imag;
    logic                 frame_valid, frame_ready, frame_err;
    logic signed [DW-1:0] x_real [N-1:0];
    logic signed [DW-1:0] x_imag [N-1:0];

    int checks = 0;
    int errors = 0;

    frame_t fq_re [$];
    frame_t fq_im [$];
    frame_t part_re, part_im;
    int     part_len;
    logic   err_m;

    fft_8p_in_buffer #(.DATA_WIDTH(DW), .N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_real     (s_real),
        .s_imag     (s_imag),
        .s_last     (s_last),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .x_real     (x_real),
        .x_imag     (x_imag),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output slot that holds sample k of a frame
    function automatic int perm(input int k);
        int r;
`ifdef FFT_IN_BITREV_EN
        r = 0;
        for (int b = 0; b < LG; b++) r = r * 2 + ((k >> b) & 1);
`else
        r = k;
`endif
        return r;
    endfunction

    task automatic model_reset();
        fq_re.delete();
        fq_im.delete();
        part_re  = '0;
        part_im  = '0;
        part_len = 0;
        err_m    = 1'b0;
    endtask

    task automatic check_outputs();
        check("s_ready", DW'(s_ready), DW'(fq_re.size() < 2));
        check("frame_valid", DW'(frame_valid), DW'(fq_re.size() > 0));
        check("frame_err", DW'(frame_err), DW'(err_m));
        if (fq_re.size() > 0) begin
            for (int a = 0; a < N; a++) begin
                check("x_real", x_real[a], fq_re[0][perm(a)]);
                check("x_imag", x_imag[a], fq_im[0][perm(a)]);
            end
        end
    endtask

    // One clock: drive inputs, compare against the model, advance the model at the edge
    task automatic cycle(input logic r, input logic v, input int re, input int im,
                         input logic last, input logic fr, output logic acc);
        logic rel;
        rst         = r;
        s_valid     = v;
        s_real      = DW'(re);
        s_imag      = DW'(im);
        s_last      = last;
        frame_ready = fr;
        #1;
        check_outputs();
        rel = (fq_re.size() > 0) && fr;
        acc = v && (fq_re.size() < 2) && !r;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (rel) begin
                void'(fq_re.pop_front());
                void'(fq_im.pop_front());
            end
            if (acc) begin
                if (part_len == 0) begin
                    part_re = '0;
                    part_im = '0;
                end
                part_re[part_len] = DW'(re);
                part_im[part_len] = DW'(im);
                if (last != (part_len == N - 1)) err_m = 1'b1;
                if (last || part_len == N - 1) begin
                    fq_re.push_back(part_re);
                    fq_im.push_back(part_im);
                    part_len = 0;
                end else begin
                    part_len++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        logic acc;
        cycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, acc);
    endtask

    initial begin
        logic acc;
        int   idx;
        int   first_b;
        int   len;
        logic lst;
        logic [DW-1:0] br_exp [N];
        br_exp = '{16'd0, 16'd4, 16'd2, 16'd6, 16'd1, 16'd5, 16'd3, 16'd7};

        rst = 1'b1; s_valid = 1'b0; s_real = '0; s_imag = '0; s_last = 1'b0; frame_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();

        #1;
        check("rst_s_ready", DW'(s_ready), DW'(1));
        check("rst_frame_valid", DW'(frame_valid), DW'(0));
        check("rst_frame_err", DW'(frame_err), DW'(0));
        for (int k = 0; k < N; k++) begin
            check("rst_x_real", x_real[k], '0);
            check("rst_x_imag", x_imag[k], '0);
        end

        // Natural frame: k+1 / -(k+1)
        for (int k = 0; k < N; k++) cycle(1'b0, 1'b1, k + 1, -(k + 1), k == N - 1, 1'b1, acc);
        #1;
        check("nat_valid", DW'(frame_valid), DW'(1));
        check("nat_err", DW'(frame_err), DW'(0));
        for (int k = 0; k < N; k++) begin
            check("nat_x_real", x_real[perm(k)], DW'(k + 1));
            check("nat_x_imag", x_imag[perm(k)], DW'(-(k + 1)));
        end
        cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, acc);
        cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, acc);

`ifdef FFT_IN_BITREV_EN
        do_reset();
        for (int k = 0; k < N; k++) cycle(1'b0, 1'b1, k, 0, k == N - 1, 1'b0, acc);
        #1;
        for (int a = 0; a < N; a++) check("bitrev_x_real", x_real[a], br_exp[a]);
`endif

        // Back-pressure: both banks fill, one-cycle release, stream resumes without loss
        do_reset();
        idx = 0;
        for (int c = 0; c < 17; c++) begin
            cycle(1'b0, 1'b1, idx, -idx, (idx % N) == N - 1, 1'b0, acc);
            if (acc) idx++;
        end
        #1;
        check("bp_accepted", DW'(idx), DW'(16));
        check("bp_stall", DW'(s_ready), DW'(0));
        cycle(1'b0, 1'b1, idx, -idx, 1'b0, 1'b1, acc);
        #1;
        check("bp_resume", DW'(s_ready), DW'(1));
        for (int k = 0; k < N; k++) check("bp_frame2", x_real[perm(k)], DW'(8 + k));
        while (idx < 20) begin
            cycle(1'b0, 1'b1, idx, -idx, (idx % N) == N - 1, 1'b0, acc);
            if (acc) idx++;
        end

        // Early s_last on index 4
        do_reset();
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, k + 1, k + 100, k == 4, 1'b0, acc);
        #1;
        check("early_err", DW'(frame_err), DW'(1));
        for (int k = 0; k < N; k++) check("early_pad", x_real[perm(k)], (k < 5) ? DW'(k + 1) : '0);
        cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, acc);
        for (int k = 0; k < N; k++) cycle(1'b0, 1'b1, 50 + k, k, k == N - 1, 1'b0, acc);
        #1;
        check("early_sticky", DW'(frame_err), DW'(1));
        check("early_next_idx0", x_real[perm(0)], DW'(50));

        // Reset after three accepted samples
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 7, 7, 1'b0, 1'b1, acc);
        do_reset();
        #1;
        check("midrst_valid", DW'(frame_valid), DW'(0));
        check("midrst_ready", DW'(s_ready), DW'(1));
        check("midrst_err", DW'(frame_err), DW'(0));
        for (int k = 0; k < N; k++) cycle(1'b0, 1'b1, 200 + k, k, k == N - 1, 1'b0, acc);

        // Release of one bank on the same edge the other bank closes
        for (int k = 0; k < N; k++) cycle(1'b0, 1'b1, 300 + k, -k, k == N - 1, k == N - 1, acc);
        #1;
        check("swap_valid", DW'(frame_valid), DW'(1));
        check("swap_x_real", x_real[perm(0)], DW'(300));
        check("swap_x_last", x_real[perm(N - 1)], DW'(300 + N - 1));
        cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, acc);

        // Random stream with ragged frames, back-pressure and occasional reset
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            len = part_len;
            if (len == N - 1) lst = ($urandom_range(0, 15) != 0);
            else              lst = ($urandom_range(0, 19) == 0);
            first_b = $urandom_range(0, 3);
            cycle($urandom_range(0, 299) == 0, first_b != 0, int'($urandom), int'($urandom),
                  lst, $urandom_range(0, 2) != 0, acc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
